// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch buffer with jump folding, conditional-jump stall and end-of-program halt
module ifu_prefetch #(
  parameter int          ADDR_W  = 8,
  parameter int          INSTR_W = 16,
  parameter int          DEPTH   = 4,
  parameter logic [3:0]  EOP     = 4'd15,
  parameter logic [3:0]  JMP     = 4'd14,
  parameter logic [3:0]  JMPS    = 4'd13
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               fetch_enable_i,
  output logic               mem_req_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  input  logic [INSTR_W-1:0] mem_rdata_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  input  logic               exec_idle_i,
  input  logic               cf_i,
  output logic               halt_o,
  output logic [1:0]         halt_cause_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {RUN, WAIT_CF, DRAIN, HALT} state_t;
  state_t state, state_nx;

  logic [INSTR_W-1:0] fifo [DEPTH];
  logic [PW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count, count_nx;
  logic [ADDR_W-1:0]  pc, req_pc, rv_addr, jmps_addr;
  logic               rvalid, rvalid_nx;
  logic [INSTR_W-1:0] head;
  logic [3:0]         head_op, ret_op;
  logic               empty, head_marker, ret, ret_jmp, ret_jmps, ret_eop;
  logic               push, pop, resolve, issue, halt_eop, halt_eom;

  always_comb begin
    head          = fifo[rd_ptr];
    head_op       = head[INSTR_W-1 -: 4];
    empty         = (count == '0);
    head_marker   = !empty && (head_op == JMPS || head_op == EOP);
    instr_valid_o = (state != HALT) && !empty && !head_marker;
    instr_o       = instr_valid_o ? head : '0;

    // rvalid marks the cycle in which mem_rdata_i carries the word of the previous request
    ret      = rvalid && (state != HALT);
    ret_op   = mem_rdata_i[INSTR_W-1 -: 4];
    ret_jmp  = ret && (ret_op == JMP);
    ret_jmps = ret && (ret_op == JMPS);
    ret_eop  = ret && (ret_op == EOP);

    push     = ret && !ret_jmp;
    pop      = instr_valid_o && instr_ready_i;
    resolve  = (state == WAIT_CF) && !empty && (head_op == JMPS) && exec_idle_i;
    halt_eop = (state == DRAIN) && !empty && (head_op == EOP) && exec_idle_i;
    halt_eom = (state == DRAIN) && empty && !rvalid && !mem_req_o && exec_idle_i;

    count_nx  = count + CW'(push) - CW'(pop) - CW'(resolve);
    rvalid_nx = mem_req_o && !(ret_jmp || ret_jmps || ret_eop);

    state_nx = state;
    req_pc   = pc;
    case (state)
      RUN, DRAIN: begin
        if (ret_jmp) begin
          state_nx = RUN;
          req_pc   = mem_rdata_i[ADDR_W-1:0];
        end else if (ret_jmps) begin
          state_nx = WAIT_CF;
        end else if (ret_eop) begin
          state_nx = DRAIN;
        end else if (halt_eop || halt_eom) begin
          state_nx = HALT;
        end
      end
      WAIT_CF: begin
        if (resolve) begin
          if (cf_i) begin
            state_nx = RUN;
            req_pc   = head[ADDR_W-1:0];
          end else if (jmps_addr == LAST_ADDR) begin
            state_nx = DRAIN;
          end else begin
            state_nx = RUN;
            req_pc   = jmps_addr + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // occupancy counts buffered entries plus the read still outstanding after this edge
    issue = (state_nx == RUN) && fetch_enable_i &&
            (({1'b0, count_nx} + (CW+1)'(rvalid_nx)) < (CW+1)'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (push) fifo[wr_ptr] <= mem_rdata_i;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= RUN;
      pc           <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      rvalid       <= 1'b0;
      rv_addr      <= '0;
      jmps_addr    <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      halt_o       <= 1'b0;
      halt_cause_o <= 2'b00;
    end else begin
      state     <= (issue && req_pc == LAST_ADDR) ? DRAIN : state_nx;
      count     <= count_nx;
      rvalid    <= rvalid_nx;
      rv_addr   <= mem_addr_o;
      mem_req_o <= issue;
      if (issue) begin
        mem_addr_o <= req_pc;
        pc         <= (req_pc == LAST_ADDR) ? req_pc : req_pc + 1'b1;
      end else begin
        pc <= req_pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop || resolve) rd_ptr <= rd_ptr + 1'b1;
      if (ret_jmps) jmps_addr <= rv_addr;
      if (state_nx == HALT && state != HALT) begin
        halt_o       <= 1'b1;
        halt_cause_o <= halt_eop ? 2'b01 : 2'b10;
      end
    end
  end
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb/tb_ifu_prefetch.sv - scoreboard bench for ifu_prefetch against a program-order reference model
module tb_ifu_prefetch;
  localparam int IW = 16;
  localparam logic [3:0] OP_EOP = 4'd15, OP_JMP = 4'd14, OP_JMPS = 4'd13;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          fetch_enable_i = 1'b0;
  logic          mem_req_o;
  logic [7:0]    mem_addr_o;
  logic [IW-1:0] mem_rdata_i = '0;
  logic [IW-1:0] instr_o;
  logic          instr_valid_o;
  logic          instr_ready_i = 1'b0;
  logic          exec_idle_i = 1'b0;
  logic          cf_i = 1'b0;
  logic          halt_o;
  logic [1:0]    halt_cause_o;

  ifu_prefetch #(.ADDR_W(8), .INSTR_W(IW), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n), .fetch_enable_i(fetch_enable_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .instr_o(instr_o), .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .exec_idle_i(exec_idle_i), .cf_i(cf_i), .halt_o(halt_o), .halt_cause_o(halt_cause_o)
  );

  always #5 clock = ~clock;

  logic [IW-1:0] mem [256];
  logic [IW-1:0] exp_q [$];
  int            exp_cause;
  int            n_cmp = 0, n_fail = 0;
  int            accepted = 0, last_req = -1, max_req = -1;
  bit            hold_pend = 0;
  logic [IW-1:0] held = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // code memory: one-cycle read latency, junk on the bus when not requested
  initial forever begin
    @(posedge clock);
    mem_rdata_i <= mem_req_o ? mem[mem_addr_o] : IW'($urandom);
  end

  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      hold_pend = 0;
      last_req  = -1;
    end else begin
      if (mem_req_o) begin
        if (last_req >= 0) chk("req_no_wrap", int'(mem_addr_o) >= last_req, 1);
        last_req = int'(mem_addr_o);
        if (last_req > max_req) max_req = last_req;
      end
      if (hold_pend) begin
        chk("hold_valid", instr_valid_o, 1);
        chk("hold_instr", instr_o, held);
      end
      if (instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) chk("queue_nonempty", exp_q.size(), 1);
        else begin
          chk("instr", instr_o, exp_q.pop_front());
          accepted++;
        end
      end
      hold_pend = instr_valid_o && !instr_ready_i;
      held      = instr_o;
    end
  end

  function automatic logic [IW-1:0] rand_normal();
    logic [3:0] op;
    op = 4'($urandom_range(12));
    return {op, 12'($urandom)};
  endfunction

  task automatic fill_normal();
    for (int a = 0; a < 256; a++) mem[a] = rand_normal();
  endtask

  task automatic gen_random();
    int r, hi;
    for (int a = 0; a < 256; a++) begin
      r  = int'($urandom_range(99));
      hi = (a + 20 > 255) ? 255 : a + 20;
      if (a < 250 && r < 4)      mem[a] = {OP_JMP,  4'h0, 8'($urandom_range(hi, a + 1))};
      else if (a < 250 && r < 8) mem[a] = {OP_JMPS, 4'h0, 8'($urandom_range(hi, a + 1))};
      else if (r < 9)            mem[a] = {OP_EOP, 12'h0};
      else                       mem[a] = rand_normal();
    end
  endtask

  // walks the program in execution order and lists what the consumer must see
  task automatic build_model(input bit cf);
    int pc;
    logic [IW-1:0] w;
    exp_q.delete();
    exp_cause = 0;
    pc = 0;
    for (int guard = 0; guard < 4000 && exp_cause == 0; guard++) begin
      w = mem[pc];
      if (w[15:12] == OP_JMP) pc = int'(w[7:0]);
      else if (w[15:12] == OP_EOP) exp_cause = 1;
      else begin
        if (w[15:12] != OP_JMPS) exp_q.push_back(w);
        if (w[15:12] == OP_JMPS && cf) pc = int'(w[7:0]);
        else if (pc == 255) exp_cause = 2;
        else pc++;
      end
    end
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    fetch_enable_i = 1'b0;
    instr_ready_i  = 1'b0;
    exec_idle_i    = 1'b0;
    accepted       = 0;
    max_req        = -1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drive_until_halt(input int rdy_pct, input int idle_pct, input int fe_pct,
                                  input bit hold_idle, input string tag);
    bit done;
    done = 0;
    for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
      @(posedge clock);
      #1;
      if (halt_o) done = 1;
      if (hold_idle && cyc == 30) begin
        chk({tag, "_marker_no_valid"}, instr_valid_o, 0);
        chk({tag, "_marker_no_req"}, mem_req_o, 0);
        chk({tag, "_marker_accepted"}, accepted, 2);
      end
      instr_ready_i  = (int'($urandom_range(99)) < rdy_pct);
      exec_idle_i    = (hold_idle && cyc < 30) ? 1'b0 : (int'($urandom_range(99)) < idle_pct);
      fetch_enable_i = (int'($urandom_range(99)) < fe_pct);
    end
    chk({tag, "_halted"}, halt_o, 1);
    chk({tag, "_cause"}, halt_cause_o, exp_cause);
    chk({tag, "_left_in_queue"}, exp_q.size(), 0);
    chk({tag, "_halt_valid"}, instr_valid_o, 0);
    chk({tag, "_halt_req"}, mem_req_o, 0);
  endtask

  task automatic run_prog(input bit cf, input int rdy_pct, input int idle_pct, input int fe_pct,
                          input bit hold_idle, input string tag);
    build_model(cf);
    cf_i = cf;
    do_reset();
    drive_until_halt(rdy_pct, idle_pct, fe_pct, hold_idle, tag);
  endtask

  task automatic load_straight();
    fill_normal();
    for (int i = 0; i < 4; i++) mem[i] = 16'h1A00 + IW'(i);
    mem[4] = {OP_EOP, 12'h0};
  endtask

  initial begin
    int nreq;
    #1;
    chk("rst_req", mem_req_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_valid", instr_valid_o, 0);
    chk("rst_instr", instr_o, 0);
    chk("rst_halt", halt_o, 0);
    chk("rst_cause", halt_cause_o, 0);

    // backpressure: four requests fill the buffer, the first pop restarts fetch
    load_straight();
    build_model(0);
    do_reset();
    fetch_enable_i = 1'b1;
    exec_idle_i    = 1'b1;
    nreq = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(posedge clock);
      #1;
      if (cyc == 0) begin
        chk("first_req", mem_req_o, 1);
        chk("first_req_addr", mem_addr_o, 0);
      end
      if (mem_req_o) nreq++;
    end
    chk("bp_requests", nreq, 4);
    chk("bp_req_stopped", mem_req_o, 0);
    chk("bp_valid", instr_valid_o, 1);
    chk("bp_head", instr_o, 16'h1A00);
    instr_ready_i = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_resume_req", mem_req_o, 1);
    chk("bp_resume_addr", mem_addr_o, 4);
    drive_until_halt(100, 100, 100, 0, "bp");

    // reset with three entries buffered
    load_straight();
    build_model(0);
    do_reset();
    fetch_enable_i = 1'b1;
    exec_idle_i    = 1'b1;
    repeat (5) @(posedge clock);
    #3;
    chk("mid_valid_before", instr_valid_o, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_valid", instr_valid_o, 0);
    chk("mid_req", mem_req_o, 0);
    chk("mid_addr", mem_addr_o, 0);
    chk("mid_instr", instr_o, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("mid_refetch_req", mem_req_o, 1);
    chk("mid_refetch_addr", mem_addr_o, 0);

    load_straight();
    run_prog(0, 50, 80, 100, 0, "straight");

    fill_normal();
    mem[8'h00] = {OP_JMP, 4'h0, 8'h10};
    mem[8'h10] = {OP_JMP, 4'h0, 8'h20};
    mem[8'h20] = 16'h5A5A;
    mem[8'h21] = {OP_EOP, 12'h0};
    run_prog(0, 100, 100, 100, 0, "jmp_chain");

    for (int c = 0; c < 2; c++) begin
      fill_normal();
      mem[2]     = {OP_JMPS, 4'h0, 8'h30};
      mem[4]     = {OP_EOP, 12'h0};
      mem[8'h31] = {OP_EOP, 12'h0};
      run_prog(c[0], 100, 100, 100, 1, c == 1 ? "jmps_taken" : "jmps_fall");
    end

    fill_normal();
    run_prog(0, 100, 100, 100, 0, "eom");
    chk("eom_last_addr", max_req, 255);

    for (int k = 0; k < 8; k++) begin
      gen_random();
      run_prog(1'($urandom_range(1)), 60, 70, 80, 0, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
